// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single RAM port between the icache and dcache of NCPUS cores.
// The arbiter moves one word per RAM transaction. It takes one IDLE cycle to
// pick a winner and then holds GRANT until the RAM reports ACCESS.
//
// Priority when picking a winner:
//   1. a continuing dcache burst (same core, fewer than MAX_BURST words so far)
//   2. dcache requests, round-robin from rr_d
//   3. icache requests, round-robin from rr_i
//
// Handshake: a requester holds its REN/WEN (plus address and data) high until
// it sees its wait bit low. The wait bit is low for exactly the completion
// cycle. If the requester drops its request while granted, the transfer is
// abandoned: the RAM strobes fall in that same cycle and the arbiter returns
// to IDLE without touching the round-robin pointers.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   iREN/iaddr          icache read request and word address, one per core
//   iwait/iload         icache stall (low on completion), read data
//   dREN/dWEN           dcache read and write requests, one per core
//   daddr/dstore        dcache word address and write data, one per core
//   dwait/dload         dcache stall (low on completion), read data
//   ramREN/ramWEN       RAM read and write strobes
//   ramaddr/ramstore    RAM address and write data
//   ramload/ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   memerr              sticky error flag, cleared only by reset
//   state_dbg           current FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NCPUS     = 2,
   parameter int MAX_BURST = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NCPUS-1:0]    iREN,
   input  logic [NCPUS*32-1:0] iaddr,
   output logic [NCPUS-1:0]    iwait,
   output logic [31:0]         iload,
   input  logic [NCPUS-1:0]    dREN,
   input  logic [NCPUS-1:0]    dWEN,
   input  logic [NCPUS*32-1:0] daddr,
   input  logic [NCPUS*32-1:0] dstore,
   output logic [NCPUS-1:0]    dwait,
   output logic [31:0]         dload,
   output logic                ramREN,
   output logic                ramWEN,
   output logic [31:0]         ramaddr,
   output logic [31:0]         ramstore,
   input  logic [31:0]         ramload,
   input  logic [1:0]          ramstate,
   output logic                memerr,
   output logic                state_dbg
);

   localparam int CW  = (NCPUS > 1) ? $clog2(NCPUS) : 1;
   localparam int CW1 = CW + 1;
   localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [1:0]    RAM_ACCESS = 2'd2;
   localparam logic [1:0]    RAM_ERROR  = 2'd3;
   localparam logic [BW-1:0] BURST_LIM  = BW'(MAX_BURST - 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_q, state_n;
   logic            gnt_d_q, gnt_d_n;        // grantee is a dcache
   logic [CW-1:0]   gnt_idx_q, gnt_idx_n;    // grantee core index
   logic            last_vld_q, last_vld_n;  // last grantee is remembered
   logic            last_d_q, last_d_n;
   logic [CW-1:0]   last_idx_q, last_idx_n;
   logic [BW-1:0]   burst_q, burst_n;        // extra words granted in this burst
   logic [CW-1:0]   rr_i_q, rr_i_n;
   logic [CW-1:0]   rr_d_q, rr_d_n;
   logic            memerr_q, memerr_n;

   logic [NCPUS-1:0] d_req;
   logic [31:0]      g_iaddr, g_daddr, g_dstore;
   logic             g_iren, g_dren, g_dwen, g_req;

   assign d_req     = dREN | dWEN;
   assign iload     = ramload;
   assign dload     = ramload;
   assign memerr    = memerr_q;
   assign state_dbg = state_q;

   // First requesting core at or after ptr, wrapping modulo NCPUS.
   function automatic logic [CW-1:0] rr_pick(input logic [NCPUS-1:0] req,
                                             input logic [CW-1:0]    ptr);
      logic [CW-1:0] pick;
      logic [CW:0]   sum;
      logic          found;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NCPUS; k++) begin
         sum = {1'b0, ptr} + CW1'(k);
         if (sum >= CW1'(NCPUS)) sum = sum - CW1'(NCPUS);
         if (!found && req[sum[CW-1:0]]) begin
            pick  = sum[CW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] c);
      return (c == CW'(NCPUS - 1)) ? '0 : c + CW'(1);
   endfunction

   // Grantee's request and payload.
   always_comb begin
      g_iaddr  = '0;
      g_daddr  = '0;
      g_dstore = '0;
      g_iren   = 1'b0;
      g_dren   = 1'b0;
      g_dwen   = 1'b0;
      for (int k = 0; k < NCPUS; k++) begin
         if (gnt_idx_q == CW'(k)) begin
            g_iaddr  = iaddr[k*32 +: 32];
            g_daddr  = daddr[k*32 +: 32];
            g_dstore = dstore[k*32 +: 32];
            g_iren   = iREN[k];
            g_dren   = dREN[k];
            g_dwen   = dWEN[k];
         end
      end
   end

   assign g_req = gnt_d_q ? (g_dren | g_dwen) : g_iren;

   always_comb begin
      state_n    = state_q;
      gnt_d_n    = gnt_d_q;
      gnt_idx_n  = gnt_idx_q;
      last_vld_n = last_vld_q;
      last_d_n   = last_d_q;
      last_idx_n = last_idx_q;
      burst_n    = burst_q;
      rr_i_n     = rr_i_q;
      rr_d_n     = rr_d_q;
      memerr_n   = memerr_q;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = '1;
      dwait      = '1;

      case (state_q)
         IDLE: begin
            if (last_vld_q && last_d_q && (burst_q < BURST_LIM) && d_req[last_idx_q]) begin
               gnt_d_n   = 1'b1;
               gnt_idx_n = last_idx_q;
               burst_n   = burst_q + BW'(1);
               state_n   = GRANT;
            end else if (|d_req) begin
               gnt_d_n   = 1'b1;
               gnt_idx_n = rr_pick(d_req, rr_d_q);
               burst_n   = '0;
               state_n   = GRANT;
            end else if (|iREN) begin
               gnt_d_n   = 1'b0;
               gnt_idx_n = rr_pick(iREN, rr_i_q);
               burst_n   = '0;
               state_n   = GRANT;
            end else begin
               last_vld_n = 1'b0;
            end
         end

         GRANT: begin
            ramaddr = gnt_d_q ? g_daddr : g_iaddr;
            if (gnt_d_q) begin
               ramstore = g_dstore;
               // A write outranks a read when a dcache raises both.
               ramWEN   = g_dwen;
               ramREN   = g_dren & ~g_dwen;
            end else begin
               ramREN   = g_iren;
            end

            if (ramstate == RAM_ERROR) memerr_n = 1'b1;

            if (!g_req) begin
               state_n = IDLE;
            end else if (ramstate == RAM_ACCESS) begin
               if (gnt_d_q) begin
                  dwait[gnt_idx_q] = 1'b0;
                  rr_d_n           = next_ptr(gnt_idx_q);
               end else begin
                  iwait[gnt_idx_q] = 1'b0;
                  rr_i_n           = next_ptr(gnt_idx_q);
               end
               last_vld_n = 1'b1;
               last_d_n   = gnt_d_q;
               last_idx_n = gnt_idx_q;
               state_n    = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         gnt_d_q    <= 1'b0;
         gnt_idx_q  <= '0;
         last_vld_q <= 1'b0;
         last_d_q   <= 1'b0;
         last_idx_q <= '0;
         burst_q    <= '0;
         rr_i_q     <= '0;
         rr_d_q     <= '0;
         memerr_q   <= 1'b0;
      end else begin
         state_q    <= state_n;
         gnt_d_q    <= gnt_d_n;
         gnt_idx_q  <= gnt_idx_n;
         last_vld_q <= last_vld_n;
         last_d_q   <= last_d_n;
         last_idx_q <= last_idx_n;
         burst_q    <= burst_n;
         rr_i_q     <= rr_i_n;
         rr_d_q     <= rr_d_n;
         memerr_q   <= memerr_n;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (NCPUS=2, MAX_BURST=2). Each expected RAM
// transaction is queued as {is_dcache, core, {ramWEN,ramREN}, addr, data}
// when the stimulus is set up; every completion the DUT signals (a wait bit
// low) is packed the same way and compared with the head of the queue.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int NCPUS = 2;
   localparam int W     = 68;

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   localparam logic [1:0] OP_RD = 2'b01;
   localparam logic [1:0] OP_WR = 2'b10;

   logic                CLK;
   logic                RST;
   logic [NCPUS-1:0]    iREN;
   logic [NCPUS*32-1:0] iaddr;
   logic [NCPUS-1:0]    iwait;
   logic [31:0]         iload;
   logic [NCPUS-1:0]    dREN;
   logic [NCPUS-1:0]    dWEN;
   logic [NCPUS*32-1:0] daddr;
   logic [NCPUS*32-1:0] dstore;
   logic [NCPUS-1:0]    dwait;
   logic [31:0]         dload;
   logic                ramREN;
   logic                ramWEN;
   logic [31:0]         ramaddr;
   logic [31:0]         ramstore;
   logic [31:0]         ramload;
   logic [1:0]          ramstate;
   logic                memerr;
   logic                state_dbg;

   int               checks = 0;
   int               errors = 0;
   int               cyc    = 0;
   logic [NCPUS-1:0] done_i;
   logic [NCPUS-1:0] done_d;
   logic [W-1:0]     exp_q[$];

   logic [31:0] a0, a1, s0, s1, rd;

   mem_arbiter #(.NCPUS(NCPUS), .MAX_BURST(2)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .memerr(memerr),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] rec(input logic is_d, input logic core,
                                        input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] d);
      return {is_d, core, op, a, d};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic advance();
      @(posedge CLK);
      #1;
   endtask

   // Sample one cycle at the falling edge and score any completion.
   task automatic sample();
      logic         is_d;
      logic         core;
      logic [31:0]  data;
      logic [W-1:0] obs;
      @(negedge CLK);
      cyc++;
      done_i = ~iwait;
      done_d = ~dwait;
      check("rw_excl", W'(ramREN & ramWEN), W'(1'b0));
      if ((|done_i) || (|done_d)) begin
         check("done_onehot", W'($countones({done_i, done_d})), W'(1));
         check("load_bcast", W'({iload, dload}), W'({ramload, ramload}));
         is_d = |done_d;
         core = is_d ? done_d[1] : done_i[1];
         data = is_d ? (ramWEN ? ramstore : dload) : iload;
         obs  = rec(is_d, core, {ramWEN, ramREN}, ramaddr, data);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed %h expected none", obs);
         end
         if (exp_q.size() != 0) check("sb_done", obs, exp_q.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         sample();
         advance();
      end
   endtask

   // Run until the given requester completes; report the cycle it happened in.
   task automatic wait_done(input logic is_d, input logic core, input int maxc,
                            input int exp_cyc, input string tag);
      int at;
      at = 0;
      for (int n = 0; n < maxc; n++) begin
         sample();
         if (at == 0 && (is_d ? done_d[core] : done_i[core])) at = cyc;
         advance();
         if (at != 0) break;
      end
      check(tag, W'(at), W'(exp_cyc));
   endtask

   function automatic logic [31:0] rnd_addr();
      return 32'($urandom_range(0, 4095)) << 2;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      RST      = 1'b1;
      iREN     = '0;
      iaddr    = '0;
      dREN     = '0;
      dWEN     = '0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = ST_FREE;
      #3;
      check("rst_ramREN", W'(ramREN), W'(1'b0));
      check("rst_ramWEN", W'(ramWEN), W'(1'b0));
      check("rst_ramaddr", W'({ramaddr, ramstore}), W'(64'h0));
      check("rst_waits", W'({iwait, dwait}), W'(4'b1111));
      check("rst_memerr", W'(memerr), W'(1'b0));
      check("rst_state", W'(state_dbg), W'(1'b0));
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Single icache read; completes in the second cycle.
      cyc = 0;
      rd = $urandom;
      ramload = rd;
      ramstate = ST_ACCESS;
      iREN = 2'b01;
      iaddr[31:0] = 32'h40;
      exp_q.push_back(rec(1'b0, 1'b0, OP_RD, 32'h40, rd));
      sample();
      check("t1_idle_ren", W'(ramREN), W'(1'b0));
      check("t1_idle_wait", W'(iwait), W'(2'b11));
      advance();
      wait_done(1'b0, 1'b0, 6, 2, "t1_done_cyc");
      iREN = '0;
      idle(2);

      // dcache 0 and icache 1 together: dcache first.
      cyc = 0;
      rd = $urandom;
      ramload = rd;
      a0 = rnd_addr();
      a1 = rnd_addr();
      dREN = 2'b01;
      daddr[31:0] = a0;
      iREN = 2'b10;
      iaddr[63:32] = a1;
      exp_q.push_back(rec(1'b1, 1'b0, OP_RD, a0, rd));
      exp_q.push_back(rec(1'b0, 1'b1, OP_RD, a1, rd));
      wait_done(1'b1, 1'b0, 6, 2, "t2_d0_cyc");
      dREN = '0;
      wait_done(1'b0, 1'b1, 6, 4, "t2_i1_cyc");
      iREN = '0;
      idle(2);

      // Both icaches held high: they alternate.
      cyc = 0;
      a0 = rnd_addr();
      a1 = rnd_addr();
      iREN = 2'b11;
      iaddr = {a1, a0};
      exp_q.push_back(rec(1'b0, 1'b0, OP_RD, a0, rd));
      exp_q.push_back(rec(1'b0, 1'b1, OP_RD, a1, rd));
      wait_done(1'b0, 1'b0, 6, 2, "t2b_i0_cyc");
      wait_done(1'b0, 1'b1, 6, 4, "t2b_i1_cyc");
      iREN = '0;
      idle(2);

      // Core-1 write burst (rr_d now points at core 1) while core 0 reads.
      cyc = 0;
      rd = $urandom;
      ramload = rd;
      s0 = $urandom;
      s1 = $urandom;
      a0 = rnd_addr();
      dWEN = 2'b10;
      daddr = {32'h100, a0};
      dstore[63:32] = s0;
      dREN = 2'b01;
      exp_q.push_back(rec(1'b1, 1'b1, OP_WR, 32'h100, s0));
      exp_q.push_back(rec(1'b1, 1'b1, OP_WR, 32'h104, s1));
      exp_q.push_back(rec(1'b1, 1'b0, OP_RD, a0, rd));
      wait_done(1'b1, 1'b1, 6, 2, "t3_w0_cyc");
      daddr[63:32] = 32'h104;
      dstore[63:32] = s1;
      wait_done(1'b1, 1'b1, 6, 4, "t3_w1_cyc");
      wait_done(1'b1, 1'b0, 6, 6, "t3_yield_cyc");
      dREN = 2'b10;
      exp_q.push_back(rec(1'b1, 1'b1, OP_WR, 32'h104, s1));
      wait_done(1'b1, 1'b1, 6, 8, "t3_wen_prio_cyc");
      dREN = '0;
      dWEN = '0;
      idle(2);

      // Round-robin between single-word dcache requests.
      cyc = 0;
      rd = $urandom;
      ramload = rd;
      a0 = rnd_addr();
      a1 = rnd_addr();
      daddr = {a1, a0};
      dREN = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic c;
         c = 1'(k % 2);
         exp_q.push_back(rec(1'b1, c, OP_RD, c ? a1 : a0, rd));
         wait_done(1'b1, c, 6, 2 * k + 2, "t4_rr_cyc");
         if (k < 3) begin
            dREN[c] = 1'b0;
            idle(1);
            dREN[c] = 1'b1;
         end
      end
      dREN = '0;
      idle(2);

      // ERROR for three GRANT cycles, then ACCESS.
      cyc = 0;
      rd = $urandom;
      ramload = rd;
      a0 = rnd_addr();
      daddr[31:0] = a0;
      dREN = 2'b01;
      ramstate = ST_ERROR;
      exp_q.push_back(rec(1'b1, 1'b0, OP_RD, a0, rd));
      sample();
      check("t5_memerr_pre", W'(memerr), W'(1'b0));
      advance();
      sample();
      check("t5_grant", W'({state_dbg, ramREN, dwait}), W'({1'b1, 1'b1, 2'b11}));
      advance();
      for (int k = 0; k < 2; k++) begin
         sample();
         check("t5_err_hold", W'({memerr, dwait}), W'({1'b1, 2'b11}));
         advance();
      end
      ramstate = ST_ACCESS;
      wait_done(1'b1, 1'b0, 6, 5, "t5_done_cyc");
      dREN = '0;
      idle(2);
      check("t5_memerr_sticky", W'(memerr), W'(1'b1));

      // Abort: dcache 1 drops its read while granted; rr_d must stay on core 1.
      cyc = 0;
      a1 = rnd_addr();
      daddr[63:32] = a1;
      dREN = 2'b10;
      ramstate = ST_BUSY;
      idle(1);
      sample();
      check("t6_grant_ren", W'({state_dbg, ramREN}), W'(2'b11));
      advance();
      dREN = '0;
      sample();
      check("t6_abort_ren", W'({state_dbg, ramREN, dwait}), W'({1'b1, 1'b0, 2'b11}));
      advance();
      sample();
      check("t6_abort_idle", W'({state_dbg, ramREN}), W'(2'b00));
      advance();
      rd = $urandom;
      ramload = rd;
      a0 = rnd_addr();
      daddr[31:0] = a0;
      ramstate = ST_ACCESS;
      dREN = 2'b11;
      exp_q.push_back(rec(1'b1, 1'b1, OP_RD, a1, rd));
      wait_done(1'b1, 1'b1, 6, 6, "t6_ptr_kept_cyc");
      dREN = 2'b01;
      exp_q.push_back(rec(1'b1, 1'b0, OP_RD, a0, rd));
      wait_done(1'b1, 1'b0, 6, 8, "t6_d0_cyc");
      dREN = '0;
      idle(2);

      // Reset while a write is granted.
      cyc = 0;
      a0 = rnd_addr();
      daddr[31:0] = a0;
      dstore[31:0] = $urandom;
      dWEN = 2'b01;
      ramstate = ST_BUSY;
      idle(1);
      sample();
      check("t7_wen_before", W'({state_dbg, ramWEN}), W'(2'b11));
      #1;
      RST = 1'b1;
      #1;
      check("t7_rst_strobes", W'({ramWEN, ramREN}), W'(2'b00));
      check("t7_rst_waits", W'({iwait, dwait}), W'(4'b1111));
      check("t7_rst_state", W'({state_dbg, memerr}), W'(2'b00));
      check("t7_rst_addr", W'(ramaddr), W'(32'h0));
      dWEN = '0;
      advance();
      RST = 1'b0;
      idle(2);

      check("sb_leftover", W'(exp_q.size()), W'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
